// File: rtl/memory_access_controller_pkg.sv
// Shared types and default sizing for the memory access controller.
// The verify states exist only when MEMCTRL_WRITE_VERIFY_EN is defined.
package memctrl_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_ADDR_W       = 3;
  localparam int DEF_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_FILL  = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD       = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_FILL     = 3'd4,
    ST_RESP     = 3'd5
`ifdef MEMCTRL_WRITE_VERIFY_EN
    ,
    ST_VFY_RD   = 3'd6,
    ST_VFY_WAIT = 3'd7
`endif
  } state_t;

endpackage

// File: rtl/memory_access_controller_if.sv
// Command/response channel plus memory pin bundle for the memory access controller.
// slave = controller side, master = command source side.
interface memory_access_controller_if
  import memctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_t           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;
  logic              busy;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chip_select;
  logic              mem_rE;
  logic              mem_wE;
  logic [DATA_W-1:0] mem_dataOut;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, mem_dataOut,
    output cmd_ready, rsp_valid, rsp_data, rsp_error, busy,
           mem_data, mem_address, mem_chip_select, mem_rE, mem_wE
  );
endinterface

// File: rtl/memory_module.sv
// 8x8 synchronous memory: write on cs&wE, registered read on cs&rE (one-cycle read latency).
module memory_module #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] address,
  input  logic              chip_select,
  input  logic              rE,
  input  logic              wE,
  output logic [DATA_W-1:0] dataOut
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (chip_select && wE) r_mem[address] <= data;
    if (chip_select && rE) dataOut <= r_mem[address];
  end
endmodule

// File: rtl/memory_access_controller.sv
// Single-FSM command sequencer driving registered one-cycle memory strobes.
// Build option: MEMCTRL_WRITE_VERIFY_EN adds a read-back compare after every write strobe.
//
// state       | meaning
// IDLE        | ready for a command
// WR          | single write strobe
// RD          | single read strobe
// RD_WAIT     | wait READ_LATENCY cycles, sample dataOut in the last one
// FILL        | write strobe to the fill counter address
// RESP        | response offered until rsp_ready
// VFY_RD      | read-back strobe at the just-written address (verify build)
// VFY_WAIT    | wait READ_LATENCY cycles, compare with written value (verify build)
module memory_access_controller
  import memctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input logic i_clk,
  input logic i_rst_n,
  memory_access_controller_if.slave bus
);
  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W+1)'(DEPTH-1);
  localparam logic [2:0]      LAT_LOAD  = 3'(READ_LATENCY-1);

  state_t            r_state, w_state_nxt;
  cmd_op_t           r_op, w_op_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [ADDR_W:0]   r_fill_cnt, w_fill_nxt;
  logic [2:0]        r_lat_cnt, w_lat_nxt;
  logic [DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
  logic              r_cmd_ready;
  logic              r_mem_cs, r_mem_re, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              w_mem_cs, w_mem_re, w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic              w_accept;
  logic              w_vfy_chk;

  assign w_accept = (r_state == ST_IDLE) && r_cmd_ready && bus.cmd_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_fill_nxt     = r_fill_cnt;
    w_lat_nxt      = r_lat_cnt;
    w_rsp_data_nxt = r_rsp_data;
    w_vfy_chk      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_nxt       = bus.cmd_op;
          w_addr_nxt     = bus.cmd_addr;
          w_data_nxt     = bus.cmd_data;
          w_fill_nxt     = '0;
          w_rsp_data_nxt = (bus.cmd_op == OP_NOP) ? '0 : bus.cmd_data;
          case (bus.cmd_op)
            OP_NOP:   w_state_nxt = ST_RESP;
            OP_WRITE: w_state_nxt = ST_WR;
            OP_READ:  w_state_nxt = ST_RD;
            OP_FILL:  w_state_nxt = ST_FILL;
            default:  w_state_nxt = ST_IDLE;
          endcase
        end
      end
`ifdef MEMCTRL_WRITE_VERIFY_EN
      ST_WR, ST_FILL: begin
        w_state_nxt = ST_VFY_RD;
      end
      ST_VFY_RD: begin
        w_state_nxt = ST_VFY_WAIT;
        w_lat_nxt   = LAT_LOAD;
      end
      ST_VFY_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_vfy_chk = 1'b1;
          if (r_op == OP_FILL && r_fill_cnt != FILL_LAST) begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = r_fill_cnt + (ADDR_W+1)'(1);
          end else begin
            w_state_nxt = ST_RESP;
          end
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
`else
      ST_WR: begin
        w_state_nxt = ST_RESP;
      end
      ST_FILL: begin
        if (r_fill_cnt == FILL_LAST) w_state_nxt = ST_RESP;
        else                         w_fill_nxt  = r_fill_cnt + (ADDR_W+1)'(1);
      end
`endif
      ST_RD: begin
        w_state_nxt = ST_RD_WAIT;
        w_lat_nxt   = LAT_LOAD;
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_rsp_data_nxt = bus.mem_dataOut;
          w_state_nxt    = ST_RESP;
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Strobes are decoded from the next state so the registered pins line up with it.
    w_mem_cs   = 1'b0;
    w_mem_re   = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = '0;
    w_mem_data = '0;
    case (w_state_nxt)
      ST_WR: begin
        w_mem_cs   = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_addr = w_addr_nxt;
        w_mem_data = w_data_nxt;
      end
      ST_RD: begin
        w_mem_cs   = 1'b1;
        w_mem_re   = 1'b1;
        w_mem_addr = w_addr_nxt;
      end
      ST_FILL: begin
        w_mem_cs   = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_addr = w_fill_nxt[ADDR_W-1:0];
        w_mem_data = w_data_nxt;
      end
`ifdef MEMCTRL_WRITE_VERIFY_EN
      ST_VFY_RD: begin
        w_mem_cs   = 1'b1;
        w_mem_re   = 1'b1;
        w_mem_addr = (w_op_nxt == OP_FILL) ? w_fill_nxt[ADDR_W-1:0] : w_addr_nxt;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_NOP;
      r_addr      <= '0;
      r_data      <= '0;
      r_fill_cnt  <= '0;
      r_lat_cnt   <= '0;
      r_rsp_data  <= '0;
      r_cmd_ready <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_mem_cs    <= w_mem_cs;
      r_mem_re    <= w_mem_re;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_data  <= w_mem_data;
    end
  end

`ifdef MEMCTRL_WRITE_VERIFY_EN
  logic r_rsp_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                   r_rsp_error <= 1'b0;
    else if (w_accept)                              r_rsp_error <= 1'b0;
    else if (w_vfy_chk && bus.mem_dataOut != r_data) r_rsp_error <= 1'b1;
  end

  assign bus.rsp_error = r_rsp_error;
`else
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.cmd_ready       = r_cmd_ready;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.rsp_valid       = (r_state == ST_RESP);
  assign bus.rsp_data        = r_rsp_data;
  assign bus.mem_chip_select = r_mem_cs;
  assign bus.mem_rE          = r_mem_re;
  assign bus.mem_wE          = r_mem_we;
  assign bus.mem_address     = r_mem_addr;
  assign bus.mem_data        = r_mem_data;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench: controller against memory_module, checked every cycle by a queue-based model.
module tb_memory_access_controller;
  import memctrl_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int RL    = 1;
  localparam int DEPTH = 8;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_access_controller_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  logic [DW-1:0] w_mem_q;
  logic          r_force = 1'b0;
  assign bus.mem_dataOut = r_force ? '0 : w_mem_q;

  memory_access_controller #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  memory_module #(.DATA_W(DW), .ADDR_W(AW)) u_mem (
    .clk        (clk),
    .data       (bus.mem_data),
    .address    (bus.mem_address),
    .chip_select(bus.mem_chip_select),
    .rE         (bus.mem_rE),
    .wE         (bus.mem_wE),
    .dataOut    (w_mem_q)
  );

  typedef struct { logic [DW-1:0] data; logic err; int acc; int lat; } rsp_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;

  rsp_t          exp_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] save_mem  [DEPTH];
  bit            outstanding = 1'b0;
  bit            seen = 1'b0;
  bit            chk_en = 1'b0;
  int            cyc = 0;
  int            last_acc = 0;
  int            n_we = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int exp_lat(cmd_op_t op);
    case (op)
      OP_NOP:   return 1;
      OP_WRITE: return VFY ? 3 + RL : 2;
      OP_READ:  return 2 + RL;
      default:  return VFY ? DEPTH * (2 + RL) + 1 : DEPTH + 1;
    endcase
  endfunction

  // Per-cycle compare against the model queues and the pin invariants.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("strobe_exclusive", 32'(bus.mem_rE & bus.mem_wE), 0);
      if (!bus.mem_rE && !bus.mem_wE) begin
        check("idle_cs", 32'(bus.mem_chip_select), 0);
        check("idle_addr", 32'(bus.mem_address), 0);
        check("idle_data", 32'(bus.mem_data), 0);
      end
      check("busy", 32'(bus.busy), 32'(outstanding));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!outstanding));
      if (bus.mem_wE) begin
        n_we++;
        if (wr_q.size() == 0) fail_now("unexpected_write_strobe");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_addr", 32'(bus.mem_address), 32'(w.addr));
          check("write_data", 32'(bus.mem_data), 32'(w.data));
        end
      end
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else begin
          check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
          check("rsp_error", 32'(bus.rsp_error), 32'(exp_q[0].err));
          if (!seen) begin
            check("rsp_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
            seen = 1'b1;
          end
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            seen = 1'b0;
            outstanding = 1'b0;
          end
        end
      end
    end
  end

  task automatic send_cmd(cmd_op_t op, logic [AW-1:0] addr, logic [DW-1:0] data);
    rsp_t e;
    wr_t  w;
    bit   ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_data  = data;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      fail_now("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      return;
    end
    e.acc    = cyc;
    last_acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    e.lat = exp_lat(op);
    e.err = 1'b0;
    case (op)
      OP_NOP:   e.data = '0;
      OP_WRITE: begin
        e.data = data;
        e.err  = VFY && r_force;
        model_mem[addr] = data;
        w.addr = addr; w.data = data;
        wr_q.push_back(w);
      end
      OP_READ:  e.data = model_mem[addr];
      default: begin
        e.data = data;
        e.err  = VFY && r_force;
        for (int a = 0; a < DEPTH; a++) begin
          model_mem[a] = data;
          w.addr = AW'(a); w.data = data;
          wr_q.push_back(w);
        end
      end
    endcase
    exp_q.push_back(e);
    outstanding = 1'b1;
  endtask

  task automatic wait_valid(output logic [DW-1:0] d, output logic err, output int lat);
    d = '0; err = 1'b0; lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        d = bus.rsp_data; err = bus.rsp_error; lat = cyc - last_acc;
        return;
      end
    end
    fail_now("rsp_valid_timeout");
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200; k++) begin
      if (!outstanding) return;
      @(negedge clk);
    end
    fail_now("rsp_handshake_timeout");
  endtask

  task automatic do_cmd(cmd_op_t op, logic [AW-1:0] addr, logic [DW-1:0] data,
                        output logic [DW-1:0] d, output logic err, output int lat);
    send_cmd(op, addr, data);
    wait_valid(d, err, lat);
    wait_done();
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          err;
    int            lat;
    int            we0;
    bit            hit;

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset held for 3 cycles.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    check("rst_rsp_error", 32'(bus.rsp_error), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_mem_cs", 32'(bus.mem_chip_select), 0);
    check("rst_mem_we", 32'(bus.mem_wE), 0);
    check("rst_mem_re", 32'(bus.mem_rE), 0);
    check("rst_mem_addr", 32'(bus.mem_address), 0);
    check("rst_mem_data", 32'(bus.mem_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk_en = 1'b1;

    // WRITE then READ back.
    we0 = n_we;
    do_cmd(OP_WRITE, 3'd3, 8'h5A, d, err, lat);
    check("write_latency", 32'(lat), VFY ? 32'd4 : 32'd2);
    check("write_echo", 32'(d), 32'h5A);
    check("write_we_pulses", 32'(n_we - we0), 1);
    do_cmd(OP_READ, 3'd3, 8'h00, d, err, lat);
    check("read3_latency", 32'(lat), 3);
    check("read3_data", 32'(d), 32'h5A);

    // FILL and spot reads.
    we0 = n_we;
    do_cmd(OP_FILL, 3'd5, 8'hC3, d, err, lat);
    check("fill_latency", 32'(lat), VFY ? 32'd25 : 32'd9);
    check("fill_we_pulses", 32'(n_we - we0), 8);
    check("fill_wr_q_drained", 32'(wr_q.size()), 0);
    do_cmd(OP_READ, 3'd0, 8'h00, d, err, lat);
    check("read0_after_fill", 32'(d), 32'hC3);
    do_cmd(OP_READ, 3'd7, 8'h00, d, err, lat);
    check("read7_after_fill", 32'(d), 32'hC3);

    do_cmd(OP_NOP, 3'd6, 8'hEE, d, err, lat);
    check("nop_latency", 32'(lat), 1);
    check("nop_data", 32'(d), 0);

    // Back-pressure: response held, competing command must be ignored.
    do_cmd(OP_WRITE, 3'd3, 8'hA5, d, err, lat);
    bus.rsp_ready = 1'b0;
    send_cmd(OP_READ, 3'd3, 8'h00);
    wait_valid(d, err, lat);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = 3'd1;
    bus.cmd_data  = 8'h77;
    repeat (5) @(negedge clk);
    check("hold_rsp_valid", 32'(bus.rsp_valid), 1);
    check("hold_rsp_data", 32'(bus.rsp_data), 32'hA5);
    check("hold_cmd_ready", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_done();

    // Reset while FILL strobes address 4.
    save_mem = model_mem;
    send_cmd(OP_FILL, 3'd0, 8'h3C);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.mem_wE && bus.mem_address == 3'd4) begin hit = 1'b1; break; end
    end
    if (!hit) fail_now("fill_addr4_timeout");
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midrst_we", 32'(bus.mem_wE), 0);
    check("midrst_cs", 32'(bus.mem_chip_select), 0);
    check("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    exp_q.delete();
    wr_q.delete();
    outstanding = 1'b0;
    seen = 1'b0;
    model_mem = save_mem;
    for (int a = 0; a < 4; a++) model_mem[a] = 8'h3C;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    do_cmd(OP_READ, 3'd5, 8'h00, d, err, lat);
    check("midrst_read5", 32'(d), 32'hC3);
    do_cmd(OP_READ, 3'd7, 8'h00, d, err, lat);
    check("midrst_read7", 32'(d), 32'hC3);
    do_cmd(OP_READ, 3'd4, 8'h00, d, err, lat);
    check("midrst_read4", 32'(d), 32'hC3);
    do_cmd(OP_READ, 3'd2, 8'h00, d, err, lat);
    check("midrst_read2", 32'(d), 32'h3C);

    // Read-back path forced to zero during a write of 0xFF.
    r_force = 1'b1;
    do_cmd(OP_WRITE, 3'd2, 8'hFF, d, err, lat);
    r_force = 1'b0;
    check("forced_rsp_error", 32'(err), VFY ? 32'd1 : 32'd0);
    do_cmd(OP_READ, 3'd2, 8'h00, d, err, lat);
    check("read2_after_ff", 32'(d), 32'hFF);

    repeat (3) @(negedge clk);
    check("end_exp_q_empty", 32'(exp_q.size()), 0);
    check("end_wr_q_empty", 32'(wr_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
